// File: rtl/vlsu_pkg.sv
// rtl/vlsu_pkg.sv - shared VLSU metadata types for the meta-control path
package vlsu_pkg;

    typedef struct packed {
        logic [3:0] req_id;
        logic [1:0] eew;
        logic       is_load;
    } meta_glb_t;

    typedef struct packed {
        logic [7:0] seg_len;
        logic       last;
    } meta_seglv_t;

    typedef struct packed {
        meta_glb_t   glb;
        meta_seglv_t seglv;
    } meta_ctrl_entry_t;

endpackage

// File: rtl/meta_ctrl_queue_ptr.sv
// rtl/meta_ctrl_queue_ptr.sv - pointer counter wrapping at Depth-1 with clear and increment
module meta_ctrl_queue_ptr #(
    parameter int Depth = 4,
    parameter int PW    = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] r_ptr;

    // Explicit wrap compare so non-power-of-two depths index the array correctly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (clr_i) begin
            r_ptr <= '0;
        end else if (inc_i) begin
            if (r_ptr == PW'(Depth - 1)) r_ptr <= '0;
            else                         r_ptr <= r_ptr + PW'(1);
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/meta_ctrl_queue.sv
// rtl/meta_ctrl_queue.sv - meta-control FIFO between the VLSU control machine and data controller
// Optional same-cycle fall-through on an empty queue: VLSU_META_FALLTHROUGH_EN.
module meta_ctrl_queue #(
    parameter int  Depth        = 4,
    parameter type meta_glb_t   = logic,
    parameter type meta_seglv_t = logic,
    parameter int  CW           = $clog2(Depth + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        meta_ctrl_valid_i,
    output logic        meta_ctrl_ready_o,
    input  meta_glb_t   meta_glb_i,
    input  meta_seglv_t meta_seglv_i,
    output logic        meta_valid_o,
    input  logic        meta_ready_i,
    output meta_glb_t   meta_glb_o,
    output meta_seglv_t meta_seglv_o,
    output logic [CW-1:0] count_o,
    output logic        overflow_o
);

    localparam int PW = $clog2(Depth);

    typedef struct packed {
        meta_glb_t   glb;
        meta_seglv_t seglv;
    } entry_t;

    entry_t        r_mem [Depth];
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [PW-1:0] w_rd_ptr;
    logic [PW-1:0] w_wr_ptr;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic          w_bypass;
    logic          w_wr;
    logic          w_rd;
    entry_t        w_in;
    entry_t        w_head;

    assign w_in              = '{glb: meta_glb_i, seglv: meta_seglv_i};
    assign w_empty           = (r_count == '0);
    assign meta_ctrl_ready_o = (r_count != CW'(Depth));

`ifdef VLSU_META_FALLTHROUGH_EN
    logic w_ft;
    assign w_ft         = w_empty & meta_ctrl_valid_i & ~flush_i;
    assign meta_valid_o = ~w_empty | w_ft;
    assign w_head       = w_ft ? w_in : r_mem[w_rd_ptr];
    assign w_bypass     = w_ft & meta_ready_i;
`else
    assign meta_valid_o = ~w_empty;
    assign w_head       = r_mem[w_rd_ptr];
    assign w_bypass     = 1'b0;
`endif

    assign w_enq = meta_ctrl_valid_i & meta_ctrl_ready_o;
    assign w_deq = meta_valid_o & meta_ready_i;
    // A bypassed entry touches neither storage nor occupancy; flush wins over both.
    assign w_wr  = w_enq & ~w_bypass & ~flush_i;
    assign w_rd  = w_deq & ~w_bypass & ~flush_i;

    meta_ctrl_queue_ptr #(.Depth(Depth), .PW(PW)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (w_rd),
        .ptr_o  (w_rd_ptr)
    );

    meta_ctrl_queue_ptr #(.Depth(Depth), .PW(PW)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (w_wr),
        .ptr_o  (w_wr_ptr)
    );

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[w_wr_ptr] <= w_in;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else if (w_wr && !w_rd) begin
            r_count <= r_count + CW'(1);
        end else if (w_rd && !w_wr) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Sticky until reset: an offer while full breaks the control machine contract.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (meta_ctrl_valid_i && !meta_ctrl_ready_o) begin
            r_overflow <= 1'b1;
        end
    end

    assign meta_glb_o   = w_head.glb;
    assign meta_seglv_o = w_head.seglv;
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_meta_ctrl_queue.sv
// tb/tb_meta_ctrl_queue.sv - directed self-checking bench for meta_ctrl_queue, Depth=4
module tb_meta_ctrl_queue;
    import vlsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        meta_ctrl_valid_i;
    logic        meta_ctrl_ready_o;
    meta_glb_t   meta_glb_i;
    meta_seglv_t meta_seglv_i;
    logic        meta_valid_o;
    logic        meta_ready_i;
    meta_glb_t   meta_glb_o;
    meta_seglv_t meta_seglv_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int checks   = 0;
    int failures = 0;

    meta_ctrl_entry_t head;
    assign head = '{glb: meta_glb_o, seglv: meta_seglv_o};

    meta_ctrl_queue #(
        .Depth        (4),
        .meta_glb_t   (meta_glb_t),
        .meta_seglv_t (meta_seglv_t)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .meta_ctrl_valid_i (meta_ctrl_valid_i),
        .meta_ctrl_ready_o (meta_ctrl_ready_o),
        .meta_glb_i        (meta_glb_i),
        .meta_seglv_i      (meta_seglv_i),
        .meta_valid_o      (meta_valid_o),
        .meta_ready_i      (meta_ready_i),
        .meta_glb_o        (meta_glb_o),
        .meta_seglv_o      (meta_seglv_o),
        .count_o           (count_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic meta_ctrl_entry_t mk(input int n);
        logic [15:0] v;
        v = 16'(n * 16'd1297 + 16'h0a51);
        return meta_ctrl_entry_t'(v);
    endfunction

    task automatic offer(input meta_ctrl_entry_t e);
        meta_ctrl_valid_i = 1'b1;
        meta_glb_i        = e.glb;
        meta_seglv_i      = e.seglv;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; flush_i = 1'b0; meta_ctrl_valid_i = 1'b0; meta_ready_i = 1'b0;
        meta_glb_i = '0; meta_seglv_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (meta_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", meta_valid_o); end
        checks++; if (meta_ctrl_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", meta_ctrl_ready_o); end
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    endtask

    task automatic test_fill_and_overflow;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            offer(mk(i));
            meta_ready_i = 1'b0;
        end
        @(negedge clk_i);
        meta_ctrl_valid_i = 1'b0;
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count_o); end
        checks++; if (meta_ctrl_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", meta_ctrl_ready_o); end
        checks++; if (meta_valid_o !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", meta_valid_o); end
        checks++; if (head !== mk(0)) begin failures++; $display("FAIL full_head got=%h exp=%h", head, mk(0)); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL full_no_ovf got=%b exp=0", overflow_o); end
        offer(mk(99));
        meta_ready_i = 1'b1;
        #1;
        checks++; if (meta_ctrl_ready_o !== 1'b0) begin failures++; $display("FAIL ready_indep_valid got=%b exp=0", meta_ctrl_ready_o); end
        @(negedge clk_i);
        meta_ctrl_valid_i = 1'b0;
        meta_ready_i      = 1'b0;
        checks++; if (count_o !== 3'd3) begin failures++; $display("FAIL deq_from_full_count got=%0d exp=3", count_o); end
        checks++; if (meta_ctrl_ready_o !== 1'b1) begin failures++; $display("FAIL deq_from_full_ready got=%b exp=1", meta_ctrl_ready_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow_o); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (head !== mk(i)) begin failures++; $display("FAIL drain_head_%0d got=%h exp=%h", i, head, mk(i)); end
            meta_ready_i = 1'b1;
            @(negedge clk_i);
            meta_ready_i = 1'b0;
        end
        checks++; if (count_o !== 3'd0 || meta_valid_o !== 1'b0) begin failures++; $display("FAIL drained count=%0d valid=%b exp=0/0", count_o, meta_valid_o); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            offer(mk(10 + i));
        end
        @(negedge clk_i);
        meta_ctrl_valid_i = 1'b0;
        checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL b2b_start_count got=%0d exp=2", count_o); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (head !== mk(10 + k)) begin failures++; $display("FAIL b2b_head_%0d got=%h exp=%h", k, head, mk(10 + k)); end
            checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL b2b_count_%0d got=%0d exp=2", k, count_o); end
            offer(mk(12 + k));
            meta_ready_i = 1'b1;
            @(negedge clk_i);
        end
        meta_ctrl_valid_i = 1'b0;
        meta_ready_i      = 1'b0;
        checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL b2b_end_count got=%0d exp=2", count_o); end
        checks++; if (head !== mk(20)) begin failures++; $display("FAIL b2b_end_head got=%h exp=%h", head, mk(20)); end
        meta_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        meta_ready_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL b2b_drain_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_latency;
        @(negedge clk_i);
        offer(mk(40));
        meta_ready_i = 1'b1;
        #1;
        checks++; if (meta_valid_o !== 1'b0) begin failures++; $display("FAIL lat_same_cycle_valid got=%b exp=0", meta_valid_o); end
        @(negedge clk_i);
        meta_ctrl_valid_i = 1'b0;
        checks++; if (meta_valid_o !== 1'b1) begin failures++; $display("FAIL lat_next_valid got=%b exp=1", meta_valid_o); end
        checks++; if (head !== mk(40)) begin failures++; $display("FAIL lat_head got=%h exp=%h", head, mk(40)); end
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL lat_count got=%0d exp=1", count_o); end
        @(negedge clk_i);
        meta_ready_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL lat_deq_count got=%0d exp=0", count_o); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            offer(mk(50 + i));
        end
        @(negedge clk_i);
        checks++; if (count_o !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count_o); end
        offer(mk(53));
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i           = 1'b0;
        meta_ctrl_valid_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count_o); end
        checks++; if (meta_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", meta_valid_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL flush_keeps_ovf got=%b exp=1", overflow_o); end
        @(negedge clk_i);
        checks++; if (meta_valid_o !== 1'b0) begin failures++; $display("FAIL flush_dropped_valid got=%b exp=0", meta_valid_o); end
        offer(mk(54));
        @(negedge clk_i);
        meta_ctrl_valid_i = 1'b0;
        checks++; if (head !== mk(54) || count_o !== 3'd1) begin failures++; $display("FAIL flush_next_entry got=%h/%0d exp=%h/1", head, count_o, mk(54)); end
        meta_ready_i = 1'b1;
        @(negedge clk_i);
        meta_ready_i = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            offer(mk(60 + i));
        end
        @(negedge clk_i);
        meta_ctrl_valid_i = 1'b0;
        checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL arst_pre_count got=%0d exp=2", count_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (meta_valid_o !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", meta_valid_o); end
        checks++; if (meta_ctrl_ready_o !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", meta_ctrl_ready_o); end
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", count_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL arst_ovf got=%b exp=0", overflow_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (meta_valid_o !== 1'b0) begin failures++; $display("FAIL arst_post_valid got=%b exp=0", meta_valid_o); end
    endtask

    initial begin
        test_reset();
        test_fill_and_overflow();
        test_back_to_back();
        test_latency();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
